rr_dispatch: RTL and testbench
==============================

# rr_dispatch

Round-robin job dispatcher for the attention-score engine: accepts one job stream on a valid/ready input and hands each job to one of N worker lanes, choosing the next idle lane in rotating priority order. It is the 1→N counterpart of the N→1 round-robin arbiter. It tracks per-lane occupancy: a lane is busy from dispatch until that worker pulses `done`. It holds each job in a single output stage until the chosen lane accepts it.

## Interface
Parameters:
- `N`, 8, number of worker lanes (≥1)
- `DW`, 32, job payload width

Ports:
- `clk` input 1: single clock, all state on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: job offered
- `in_ready` output 1: job accepted when `in_valid && in_ready`
- `in_data` input DW: job payload
- `out_valid` output N: one-hot, the lane currently offered the staged job (all-zero when stage empty)
- `out_data` output DW: staged payload, shared by all lanes
- `out_ready` input N: per-lane accept; only the bit matching `out_valid` is observed
- `done` input N: per-lane completion pulse; frees the lane
- `busy` output N: registered lane-occupancy bitmap
- `err_done` output 1: sticky; set when `done[i]` arrives while `busy[i]==0`

## Operation
- State: `busy[N]`, rotating one-hot pointer `ptr[N]`, stage register (`stage_valid`, `stage_tgt[N]`, `stage_data[DW]`), `err_done`.
- Pick: `sel` = the first set bit of `~busy` at or after `ptr`, searching cyclically. `sel` is computed from the registered `busy`. The search uses the doubled-vector method: `{x,x} & ~({x,x} - ptr)`, then OR the two halves.
- `out_fire` = `|(out_valid & out_ready)`.
- `in_ready` = `(!stage_valid || out_fire) && |(~busy)`.
- On input accept:
  - `stage_data <= in_data`, `stage_tgt <= sel`, `stage_valid <= 1`
  - `busy[sel] <= 1`
  - `ptr <=` `sel` rotated left by one (`sel[N-1]` wraps to bit 0)
- On `out_fire` without an accept: `stage_valid <= 0`.
- `out_valid = stage_valid ? stage_tgt : 0`; `out_data = stage_data`.
- `done[i]` with `busy[i]`: `busy[i] <= 0`. Several `done` bits may be asserted in one cycle.
- Precedence: the lane chosen by an accept can never receive `done` in the same cycle, because `sel` only picks lanes that are not busy. A `done` on an idle lane leaves `busy` unchanged and sets `err_done`, which is cleared only by reset.
- `ptr` does not move when there is no accept.
- N=1: `ptr` stays at 1; the block degenerates to a one-lane occupancy gate.

## Timing
- Reset values: `busy=0`, `ptr=1` (lane 0), `stage_valid=0`, `out_valid=0`, `out_data=0`, `err_done=0`. Consequently `in_ready=1` from the first cycle after reset release.
- Latency: a job accepted in cycle t is offered on `out_*` in cycle t+1.
- Throughput: one job per cycle while lanes accept immediately and idle lanes remain.
- Lane freeing: `done` in cycle t makes the lane selectable in cycle t+1. It does not raise `in_ready` in cycle t.
- Backpressure: while `out_ready[tgt]==0`, `out_valid` and `out_data` hold stable and `in_ready=0`.
- All lanes busy: `in_ready=0` regardless of stage state.
- Reset mid-operation: the staged job is dropped and all lanes are marked idle immediately, asynchronously.

## Structure
- Shared package `epu_rr_pkg`: `N`/`DW` defaults and a `rotl1` one-hot rotate function, shared with the arbiter.
- Sub-module `rr_pick` (combinational): inputs `N`-bit `avail` and `ptr`; outputs one-hot `sel` and `any`. It holds the cyclic-priority search; `rr_dispatch` holds all registers.

## Test plan
- Reset, N=4: after `rst_n` rises → `in_ready=1`, `busy=0000`, `out_valid=0000`, `err_done=0`.
- Four back-to-back jobs 0xA..0xD with `out_ready=1111` and no `done`:
  - `out_valid` = 0001, 0010, 0100, 1000 on cycles t+1..t+4, with matching data
  - `in_ready=0` once `busy=1111`
- Wrap and priority: from `busy=1111`, pointer at lane 0, pulse `done=0110` → the next job goes to lane 1, the following job to lane 2, and the pointer is then at lane 3.
- Backpressure: hold `out_ready=0000` for 5 cycles with a staged job for lane 2 → `out_valid=0100` and `out_data` stable, `in_ready=0`. Raising `out_ready[2]` → the stage empties, and a pending input is accepted the same cycle.
- Error: `done[3]` pulsed while `busy[3]=0` → `busy` unchanged, `err_done=1` and it stays 1 until reset.
- Reset mid-job: assert `rst_n=0` with the stage full and `busy=0011` → outputs return to reset values immediately; the first job after reset goes to lane 0.

Source files
------------

// File: rtl/epu_rr_pkg.sv
// Shared defaults and helpers for the round-robin arbiter/dispatcher family.
// Latency: n/a (package only).
// Backpressure: n/a.
package epu_rr_pkg;

    localparam int N_DEF  = 8;   // default lane count
    localparam int DW_DEF = 32;  // default payload width
    localparam int MAX_N  = 64;  // widest lane vector rotl1 can handle

    // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
    // Bits at and above n are returned as zero. With n=1 the vector is unchanged.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                if (i == n - 1) begin
                    r[0] = v[i];
                end else begin
                    r[i+1] = v[i];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic-priority picker: first set bit of avail at or after one-hot ptr.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
// Ports: avail (candidate lanes), ptr (one-hot start), sel (one-hot winner), any (some lane available).
module rr_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0] avail,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] sel,
    output logic         any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] hit;

    // Doubling the vector makes the wrap-around search a plain linear one.
    // Subtracting ptr borrows through the zero bits from ptr upward and
    // clears the first set bit at or above ptr; masking with the original
    // isolates exactly that bit.
    assign dbl = {avail, avail};
    assign hit = dbl & ~(dbl - {{N{1'b0}}, ptr});
    assign sel = hit[N-1:0] | hit[2*N-1:N];
    assign any = |avail;

endmodule

// File: rtl/rr_dispatch.sv
// Round-robin 1->N job dispatcher with per-lane occupancy and one output stage.
// Latency: job accepted in cycle t is offered to its lane in cycle t+1.
// Backpressure: stage holds until the target lane accepts; in_ready drops when stage is stuck or all lanes busy.
// Ports: in_valid/in_ready/in_data (job input), out_valid (one-hot lane)/out_data/out_ready,
//        done (per-lane completion), busy (occupancy), err_done (sticky done-on-idle flag).
module rr_dispatch
    import epu_rr_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [N-1:0]  out_valid,
    output logic [DW-1:0] out_data,
    input  logic [N-1:0]  out_ready,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  busy,
    output logic          err_done
);

    logic [N-1:0]  ptr;
    logic [N-1:0]  sel;
    logic          any_idle;
    logic          stage_valid;
    logic [N-1:0]  stage_tgt;
    logic [DW-1:0] stage_data;
    logic          out_fire;
    logic          accept;

    // Selection works only from the registered busy map, so a done pulse
    // frees its lane for the following cycle, never the current one.
    rr_pick #(.N(N)) u_pick (
        .avail (~busy),
        .ptr   (ptr),
        .sel   (sel),
        .any   (any_idle)
    );

    assign out_valid = stage_valid ? stage_tgt : '0;
    assign out_data  = stage_data;
    assign out_fire  = |(out_valid & out_ready);
    assign in_ready  = (!stage_valid || out_fire) && any_idle;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            ptr         <= N'(1);
            stage_valid <= 1'b0;
            stage_tgt   <= '0;
            stage_data  <= '0;
            err_done    <= 1'b0;
        end else begin
            // sel is never a busy lane, so clearing by done and setting by
            // accept cannot collide on a legitimately busy bit.
            busy <= (busy & ~done) | (accept ? sel : '0);

            if (|(done & ~busy)) begin
                err_done <= 1'b1;
            end

            if (accept) begin
                stage_valid <= 1'b1;
                stage_tgt   <= sel;
                stage_data  <= in_data;
                ptr         <= N'(rotl1(MAX_N'(sel), N));
            end else if (out_fire) begin
                stage_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_dispatch.sv
module tb_rr_dispatch;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [N-1:0]  out_valid;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_ready = '0;
    logic [N-1:0]  done = '0;
    logic [N-1:0]  busy;
    logic          err_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rr_dispatch #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done),
        .busy      (busy),
        .err_done  (err_done)
    );

    // Reference model: lanes as an array, pointer as a lane index.
    bit            m_busy[N];
    int            m_ptr;
    bit            m_sv;
    int            m_tgt;
    logic [DW-1:0] m_data;
    bit            m_err;
    int            p_sel;
    bit            p_fire;
    bit            p_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] m_busy_vec();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_ptr  = 0;
        m_sv   = 1'b0;
        m_tgt  = 0;
        m_data = '0;
        m_err  = 1'b0;
    endtask

    // Compare all outputs with what the model predicts for the current inputs.
    task automatic compare(input string tag);
        logic [N-1:0] exp_ov;
        bit           exp_ir;
        p_sel = -1;
        for (int k = 0; k < N; k++) begin
            int lane;
            lane = (m_ptr + k) % N;
            if (!m_busy[lane] && p_sel < 0) p_sel = lane;
        end
        p_fire = m_sv && out_ready[m_tgt];
        exp_ir = (!m_sv || p_fire) && (p_sel >= 0);
        p_acc  = in_valid && exp_ir;
        exp_ov = m_sv ? N'(1 << m_tgt) : '0;
        chk({tag, ".in_ready"},  64'(in_ready),  64'(exp_ir));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
        chk({tag, ".out_data"},  64'(out_data),  64'(m_data));
        chk({tag, ".busy"},      64'(busy),      64'(m_busy_vec()));
        chk({tag, ".err_done"},  64'(err_done),  64'(m_err));
    endtask

    task automatic m_update();
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                if (m_busy[i]) m_busy[i] = 1'b0;
                else           m_err = 1'b1;
            end
        end
        if (p_acc) begin
            m_data         = in_data;
            m_tgt          = p_sel;
            m_sv           = 1'b1;
            m_busy[p_sel]  = 1'b1;
            m_ptr          = (p_sel + 1) % N;
        end else if (p_fire) begin
            m_sv = 1'b0;
        end
    endtask

    // One clock: check at the falling edge, advance model after the rising edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        #1;
        m_update();
    endtask

    initial begin
        m_reset();

        // Reset
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        chk("rst.busy",      64'(busy),      64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.err_done",  64'(err_done),  64'd0);
        chk("rst.out_data",  64'(out_data),  64'd0);
        @(posedge clk);
        #1;

        // Four back-to-back jobs, lanes accept immediately
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hA + 32'(k);
            cycle("b2b");
            chk("b2b.lane", 64'(out_valid), 64'(4'b0001 << k));
            chk("b2b.data", 64'(out_data),  64'(32'hA + 32'(k)));
        end
        #1;
        chk("full.in_ready", 64'(in_ready), 64'd0);
        chk("full.busy",     64'(busy),     64'hF);
        in_valid = 1'b0;
        cycle("drain");

        // Wrap and priority: pointer is at lane 0, free lanes 1 and 2
        done = 4'b0110;
        cycle("done12");
        done = 4'b0000;
        in_valid = 1'b1;
        in_data  = 32'h11;
        cycle("wrap1");
        chk("wrap1.lane", 64'(out_valid), 64'b0010);
        in_data = 32'h22;
        cycle("wrap2");
        chk("wrap2.lane", 64'(out_valid), 64'b0100);

        // Backpressure on lane 2; lane 0 freed so a pending input exists
        out_ready = 4'b0000;
        in_data   = 32'h33;
        done      = 4'b0001;
        cycle("bp0");
        done = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            cycle("bp");
            chk("bp.lane", 64'(out_valid), 64'b0100);
            chk("bp.data", 64'(out_data),  64'h22);
        end
        out_ready = 4'b0100;
        #1;
        chk("bp.release_ready", 64'(in_ready), 64'd1);
        cycle("bp_rel");
        chk("bp.next_lane", 64'(out_valid), 64'b0001);
        chk("bp.next_data", 64'(out_data),  64'h33);
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        cycle("bp_drain");

        // Error: free lane 3 legitimately, then pulse it again while idle
        done = 4'b1000;
        cycle("err_free");
        cycle("err_pulse");
        chk("err.flag", 64'(err_done), 64'd1);
        chk("err.busy", 64'(busy),     64'b0111);
        done = 4'b0000;
        for (int k = 0; k < 3; k++) cycle("err_hold");

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = N'($urandom);
            done      = ($urandom_range(0, 2) == 0) ? (N'($urandom) & m_busy_vec()) : '0;
            if ($urandom_range(0, 40) == 0) done = N'($urandom);
            cycle("rnd");
        end

        // Reset mid-job: stage full for lane 1, busy=0011
        in_valid = 1'b0; out_ready = '0; done = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        cycle("mr_a");
        in_data = 32'h66;
        cycle("mr_b");
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        chk("mr.busy",  64'(busy),      64'b0011);
        chk("mr.stage", 64'(out_valid), 64'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr.rst_busy",  64'(busy),      64'd0);
        chk("mr.rst_valid", 64'(out_valid), 64'd0);
        chk("mr.rst_data",  64'(out_data),  64'd0);
        chk("mr.rst_err",   64'(err_done),  64'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        cycle("mr_first");
        chk("mr.first_lane", 64'(out_valid), 64'b0001);
        in_valid = 1'b0;
        cycle("mr_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
